// File: rtl/priority_encoder_7seg_scan.sv
// Debounced priority encoder driving a two-digit multiplexed 7-segment display.
// Slot 0 shows the winning bit index; slot 1 shows the number of set bits.
module priority_encoder_7seg_scan #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  input  logic             freeze,
  output logic [6:0]       segments,
  output logic             dp,
  output logic [1:0]       digit_en,
  output logic             changed
);

  typedef struct packed {
    logic       none;
    logic [3:0] index;
    logic [3:0] count;
  } cand_t;

  localparam cand_t      CAND_NONE = '{1'b1, 4'd0, 4'd0};
  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [15:0] SCAN_LAST = 16'(REFRESH_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      4'hF:    hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  logic [WIDTH-1:0] d_q;
  cand_t            cand_s;
  cand_t            cand_q;
  cand_t            shown;
  cand_t            shown_next_s;
  logic [7:0]       stab;
  logic [7:0]       stab_next_s;
  logic             load_s;
  logic [3:0]       hi_idx_s;
  logic [3:0]       lo_idx_s;
  logic [15:0]      scan_cnt_r;
  logic [15:0]      scan_next_s;
  logic             sel_r;
  logic             sel_next_s;
  logic [6:0]       seg_next_s;
  logic             dp_next_s;
  logic [1:0]       en_next_s;

  // Encode the registered request bits; last assignment in each scan direction wins.
  always_comb begin
    hi_idx_s = 4'd0;
    lo_idx_s = 4'd0;
    cand_s   = CAND_NONE;
    for (int i = 0; i < WIDTH; i++) begin
      hi_idx_s     = d_q[i] ? 4'(i) : hi_idx_s;
      cand_s.count = cand_s.count + {3'd0, d_q[i]};
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      lo_idx_s = d_q[i] ? 4'(i) : lo_idx_s;
    end
    cand_s.none  = (d_q == '0);
    cand_s.index = mode ? lo_idx_s : hi_idx_s;
  end

  // Stability counter and display-update decision.
  always_comb begin
    if (cand_s != cand_q) begin
      stab_next_s = 8'd1;
    end else if (stab >= STAB_MAX) begin
      stab_next_s = STAB_MAX;
    end else begin
      stab_next_s = stab + 8'd1;
    end
    load_s       = !freeze && (stab_next_s == STAB_MAX) && (cand_s != shown);
    shown_next_s = load_s ? cand_s : shown;
  end

  // Encoder pipeline, stability filter and displayed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= '0;
      cand_q  <= CAND_NONE;
      stab    <= 8'd0;
      shown   <= CAND_NONE;
      changed <= 1'b0;
    end else begin
      d_q     <= data;
      cand_q  <= cand_s;
      stab    <= stab_next_s;
      shown   <= shown_next_s;
      changed <= load_s;
    end
  end

  // Scan divider; the digit select flips on every wrap.
  always_comb begin
    if (scan_cnt_r == SCAN_LAST) begin
      scan_next_s = 16'd0;
      sel_next_s  = ~sel_r;
    end else begin
      scan_next_s = scan_cnt_r + 16'd1;
      sel_next_s  = sel_r;
    end
  end

  // Decode next-state values so the registered outputs carry no extra lag.
  always_comb begin
    if (sel_next_s == 1'b0) begin
      en_next_s  = 2'b01;
      seg_next_s = shown_next_s.none ? 7'h00 : hex7(shown_next_s.index);
      dp_next_s  = shown_next_s.none;
    end else begin
      en_next_s  = 2'b10;
      seg_next_s = hex7(shown_next_s.count);
      dp_next_s  = 1'b0;
    end
  end

  // Scan state and registered display drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= 16'd0;
      sel_r      <= 1'b0;
      segments   <= 7'h00;
      dp         <= 1'b1;
      digit_en   <= 2'b01;
    end else begin
      scan_cnt_r <= scan_next_s;
      sel_r      <= sel_next_s;
      segments   <= seg_next_s;
      dp         <= dp_next_s;
      digit_en   <= en_next_s;
    end
  end

endmodule

// File: tb/tb_priority_encoder_7seg_scan.sv
// Directed bench: expected displayed values are queued when stimulus is driven
// and retired by a monitor on each changed pulse.
module tb_priority_encoder_7seg_scan;

  typedef struct packed {
    logic       none;
    logic [3:0] idx;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       mode = 1'b0;
  logic       freeze = 1'b0;
  logic [6:0] segments;
  logic       dp;
  logic [1:0] digit_en;
  logic       changed;

  int   checks = 0;
  int   failures = 0;
  int   changed_seen = 0;
  int   base;
  exp_t exp_q[$];
  exp_t cur = '{1'b1, 4'd0, 4'd0};

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  priority_encoder_7seg_scan #(
    .WIDTH(8), .STABLE_CYCLES(4), .REFRESH_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .mode(mode), .freeze(freeze),
    .segments(segments), .dp(dp), .digit_en(digit_en), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Retire one expected display value per changed pulse.
  always @(negedge clk) begin
    if (changed === 1'b1) begin
      changed_seen++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_changed observed=1 expected=0");
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_slot(input string tag, input logic [1:0] target);
    int n = 0;
    while (digit_en !== target && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_slot"}, {6'd0, digit_en}, {6'd0, target});
  endtask

  task automatic wait_changed(input string tag);
    int n = 0;
    while (changed !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_changed"}, {7'd0, changed}, 8'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_display(input string tag);
    wait_slot(tag, 2'b01);
    chk({tag, "_seg0"}, {1'b0, segments}, {1'b0, cur.none ? 7'h00 : hex_tab[cur.idx]});
    chk({tag, "_dp0"}, {7'd0, dp}, {7'd0, cur.none});
    wait_slot(tag, 2'b10);
    chk({tag, "_seg1"}, {1'b0, segments}, {1'b0, hex_tab[cur.cnt]});
    chk({tag, "_dp1"}, {7'd0, dp}, 8'd0);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk("reset_seg", {1'b0, segments}, 8'h00);
    chk("reset_dp", {7'd0, dp}, 8'd1);
    chk("reset_en", {6'd0, digit_en}, 8'h01);
    chk("reset_changed", {7'd0, changed}, 8'd0);

    // 0x29, highest wins: exact four-edge latency, then one-cycle pulse
    data = 8'h29;
    exp_q.push_back('{1'b0, 4'd5, 4'd3});
    step(1);
    step(3);
    chk("lat_early", {7'd0, changed}, 8'd0);
    step(1);
    chk("lat_pulse", {7'd0, changed}, 8'd1);
    step(1);
    chk("lat_one_cycle", {7'd0, changed}, 8'd0);
    check_display("hi_29");

    mode = 1'b1;
    exp_q.push_back('{1'b0, 4'd0, 4'd3});
    wait_changed("lo_29");
    check_display("lo_29");

    mode = 1'b0;
    exp_q.push_back('{1'b0, 4'd5, 4'd3});
    wait_changed("hi_back");
    check_display("hi_back");

    // short glitch must be filtered
    base = changed_seen;
    data = 8'h01;
    step(2);
    data = 8'h29;
    step(10);
    chk("glitch_nochange", 8'(changed_seen - base), 8'd0);
    check_display("glitch");

    // frozen display holds while the new candidate settles
    base = changed_seen;
    freeze = 1'b1;
    data = 8'h80;
    step(10);
    chk("freeze_nochange", 8'(changed_seen - base), 8'd0);
    check_display("frozen");
    exp_q.push_back('{1'b0, 4'd7, 4'd1});
    freeze = 1'b0;
    step(1);
    chk("release_pulse", {7'd0, changed}, 8'd1);
    step(1);
    chk("release_one_cycle", {7'd0, changed}, 8'd0);
    check_display("released");

    // scan cadence from the first cycle of a slot-0 period
    wait_slot("cad_a", 2'b10);
    wait_slot("cad_b", 2'b01);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("cadence_%0d", i), {6'd0, digit_en}, ((i / 4) % 2 == 0) ? 8'h01 : 8'h02);
      step(1);
    end

    data = 8'h00;
    exp_q.push_back('{1'b1, 4'd0, 4'd0});
    wait_changed("empty");
    check_display("empty");

    data = 8'h29;
    exp_q.push_back('{1'b0, 4'd5, 4'd3});
    wait_changed("pre_rst");
    wait_slot("pre_rst", 2'b10);

    // mid-cycle async reset with an update pending
    base = changed_seen;
    data = 8'h80;
    step(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_seg", {1'b0, segments}, 8'h00);
    chk("async_dp", {7'd0, dp}, 8'd1);
    chk("async_en", {6'd0, digit_en}, 8'h01);
    chk("async_changed", {7'd0, changed}, 8'd0);
    data = 8'h00;
    cur = '{1'b1, 4'd0, 4'd0};
    step(2);
    rst = 1'b0;
    step(10);
    chk("rst_nochange", 8'(changed_seen - base), 8'd0);
    check_display("after_rst");
    chk("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_encoder_7seg_scan.md
PRIORITY_ENCODER_7SEG_SCAN -- requirements
Module: priority_encoder_7seg_scan

Interface
REQ-001 Parameter WIDTH, default 8, number of data inputs; legal range 2..15.
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical encodings required before the display updates; legal range 1..255.
REQ-003 Parameter REFRESH_DIV, default 1000, clock cycles per digit slot in the display scan; legal range 2..65535.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 data  in  WIDTH  request bits.
REQ-007 mode  in  1  priority mode: 0 = highest index wins, 1 = lowest index wins.
REQ-008 freeze  in  1  1 = hold the displayed value.
REQ-009 segments  out  7  segment drive, bit order gfedcba, active-high.
REQ-010 dp  out  1  decimal point; indicates no data on the index digit.
REQ-011 digit_en  out  2  one-hot digit enable: 01 = index digit, 10 = count digit.
REQ-012 changed  out  1  one-cycle pulse when the displayed value updates.

Function
REQ-013 data SHALL be registered each edge into d_q; all encoding SHALL use d_q only.
REQ-014 Candidate = {none, index, count}: none = (d_q == 0); index = position of the winning set bit per mode; count = number of set bits in d_q.
REQ-015 When none = 1, index SHALL be 0 and count SHALL be 0.
REQ-016 Each edge: if candidate != cand_q, then cand_q <= candidate and stab <= 1; otherwise stab <= stab + 1, saturating at STABLE_CYCLES.
REQ-017 shown SHALL load candidate on any edge where freeze = 0, next stab == STABLE_CYCLES, and candidate != shown.
REQ-018 changed SHALL be 1 for exactly the cycle following each shown update and 0 otherwise.
REQ-019 Latency: if data is sampled into d_q at edge k and then held, shown SHALL update at edge k+STABLE_CYCLES.
REQ-020 A candidate that persists for fewer than STABLE_CYCLES edges SHALL never reach shown.
REQ-021 While freeze = 1, shown SHALL hold and changed SHALL be 0; cand_q and stab SHALL keep tracking.
REQ-022 On freeze release, if the candidate is already stable and differs from shown, shown SHALL update on the first edge with freeze = 0.
REQ-023 The scan counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the digit select SHALL toggle on each wrap.
REQ-024 Slot 0: digit_en = 01; segments = hex(index), or 0000000 if none; dp = none.
REQ-025 Slot 1: digit_en = 10; segments = hex(count); dp = 0.
REQ-026 Hex table (gfedcba), values 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-027 segments, dp and digit_en SHALL decode only from registered state, with no combinational path from any input.
REQ-028 A mode change SHALL be treated as a candidate change and be subject to the same stability filter.

Reset
REQ-029 rst = 1 SHALL immediately, without waiting for a clock edge, clear d_q, stab, the scan counter and the digit select to 0, and set cand_q and shown to {none=1, 0, 0}.
REQ-030 Reset state outputs: segments = 0000000, dp = 1, digit_en = 01, changed = 0.
REQ-031 Assertion of rst mid-operation SHALL discard any pending update and must not produce a changed pulse.

Verification (WIDTH=8, STABLE_CYCLES=4, REFRESH_DIV=4)
REQ-032 Assert rst asynchronously mid-cycle -> outputs take reset values at once: segments 00, dp 1, digit_en 01.
REQ-033 data = 8'b00101001, mode = 0, sampled at edge k -> changed pulses after edge k+4; slot 0 shows 6D (5), dp 0; slot 1 shows 4F (3).
REQ-034 Same data with mode = 1 -> slot 0 shows 3F (0).
REQ-035 data goes 0x29 -> 0x01 for 2 cycles -> back to 0x29 -> no changed pulse; display still shows 5.
REQ-036 freeze = 1, data = 0x80 held for 10 cycles -> display still shows 5; release freeze -> changed pulses and slot 0 shows 07 on the next edge.
REQ-037 Steady run -> digit_en alternates 01/10 every 4 cycles; data = 0 -> slot 0 shows 00 with dp 1, slot 1 shows 3F.
